bus_if_wbuf: RTL and testbench
==============================

BUS_IF_WBUF -- requirements
Module: bus_if_wbuf

Interface
REQ-001 SHALL have parameter ADDR_W, default 30, word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter SIDX_W, default 3, slave-index width taken from cpu_addr[ADDR_W-1 -: SIDX_W].
REQ-004 SHALL have parameter LOCAL_IDX, default 1, slave index served by the SPM port.
REQ-005 SHALL have parameter WBUF_DEPTH, default 4, posted-write buffer entries; power of 2, >=2.
REQ-006 SHALL have parameter TIMEOUT, default 16, cycles in REQ+ACCESS before abort; 0 disables.
REQ-007 SHALL have ports: clk in 1, clock; rst in 1, asynchronous active-low reset.
REQ-008 SHALL have ports: pl_stall in 1, pl_flush in 1, pipeline control; busy out 1, stall request to pipeline; err out 1, one-cycle bus-timeout pulse.
REQ-009 SHALL have CPU ports: cpu_addr in ADDR_W; cpu_as_ in 1 (active low); cpu_rw in 1 (1=READ); cpu_wr_data in DATA_W; cpu_rd_data out DATA_W.
REQ-010 SHALL have SPM ports: spm_addr out ADDR_W; spm_as_ out 1; spm_rw out 1; spm_wr_data out DATA_W; spm_rd_data in DATA_W.
REQ-011 SHALL have bus ports: bus_req_ out 1; bus_grnt_ in 1; bus_addr out ADDR_W; bus_as_ out 1; bus_rw out 1; bus_wr_data out DATA_W; bus_rd_data in DATA_W; bus_rdy_ in 1 (all strobes active low).

Function
REQ-012 SHALL drive spm_addr/rw/wr_data combinationally from cpu_*; spm_as_ low only when cpu_as_ low, index==LOCAL_IDX, pl_flush=0, pl_stall=0, engine IDLE; local reads return spm_rd_data same cycle, busy=0.
REQ-013 SHALL post a remote write (cpu_as_ low, rw=WRITE, index!=LOCAL_IDX, flush=0, stall=0) into the FIFO on that clock edge with busy=0, if FIFO not full.
REQ-014 SHALL assert busy and not push when FIFO is full, including a cycle in which the head entry completes (no same-cycle pop/push bypass).
REQ-015 SHALL, for a remote read, assert busy until data is returned; read not launched until FIFO empty (write-before-read ordering).
REQ-016 SHALL run a bus engine with states IDLE, REQ, ACCESS, STALL.
REQ-017 IDLE: FIFO non-empty -> load head into bus_addr/rw/wr_data, bus_req_ low, go REQ; else pending remote read -> load cpu request, go REQ; writes have priority.
REQ-018 REQ: bus_grnt_ low -> bus_as_ low for exactly one cycle, go ACCESS.
REQ-019 ACCESS: on bus_rdy_ low -> release req_, clear addr/wr_data to 0, rw to READ; write: pop FIFO, go IDLE; read: capture rd_buf, drive bus_rd_data to cpu_rd_data same cycle, busy=0, go STALL if pl_stall=1 else IDLE.
REQ-020 STALL: cpu_rd_data=rd_buf, busy=0; go IDLE when pl_stall=0.
REQ-021 SHALL count cycles in REQ+ACCESS; reaching TIMEOUT -> release all bus strobes, pulse err one cycle, drop the write (pop) or return 0 for the read, go IDLE.
REQ-022 pl_flush=1 SHALL cancel a not-yet-launched remote read; posted writes and an in-flight access SHALL complete.
REQ-023 FIFO pointers SHALL be log2(WBUF_DEPTH)+1 bits, wrapping; full/empty from MSB compare.
REQ-024 cpu_rd_data SHALL be 0 whenever no read result is presented.

Reset
REQ-025 On rst low, asynchronously: state IDLE; bus_req_/bus_as_ high; bus_addr, bus_wr_data 0; bus_rw READ; FIFO empty; rd_buf 0; timeout counter 0; err 0.
REQ-026 Reset mid-access SHALL discard FIFO contents and in-flight transaction without further bus strobes.

Structure
REQ-027 State encoding, READ/WRITE and strobe-level constants SHALL live in shared package bus_if_pkg.
REQ-028 Posted-write buffer SHALL be sub-module bus_if_wfifo (DEPTH, WIDTH=ADDR_W+DATA_W).

Verification
REQ-029 Local read, addr idx 1, spm_rd_data=0xDEADBEEF -> cpu_rd_data=0xDEADBEEF same cycle, busy=0, bus_req_ high.
REQ-030 Five back-to-back remote writes, depth 4, grnt held high -> first four busy=0, fifth busy=1 until grant+rdy retires one.
REQ-031 Posted write to 0x10000000 then read 0x10000004 -> bus shows write before read; read busy until rdy_, returns 0x12345678.
REQ-032 Read with pl_stall=1 at rdy_ -> STALL; cpu_rd_data holds value; IDLE one cycle after stall drops.
REQ-033 bus_grnt_ never asserted, TIMEOUT=16 -> bus_req_ released, err pulses once 16 cycles after REQ entry, read returns 0.
REQ-034 rst low during ACCESS with 3 writes queued -> all bus strobes high asynchronously, FIFO empty after release.

Source files
------------

// File: rtl/bus_if_pkg.sv
// Shared encodings for the CPU bus interface: engine states, transfer direction, strobe levels.
package bus_if_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACCESS = 2'd2,
    ST_STALL  = 2'd3
  } bus_state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam logic STB_ON_  = 1'b0;
  localparam logic STB_OFF_ = 1'b1;

endpackage

// File: rtl/bus_if_wfifo.sv
// Posted-write buffer: power-of-two FIFO with wrap-bit pointers, head visible combinationally.
module bus_if_wfifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 62
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_empty = (r_wptr == r_rptr);
  assign o_head  = r_mem[r_rptr[AW-1:0]];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
    end
  end

  // Storage needs no reset: pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/bus_if_wbuf.sv
// CPU bus interface: local SPM decode, posted-write buffer and a single-master bus engine with timeout.
module bus_if_wbuf
  import bus_if_pkg::*;
#(
  parameter int unsigned ADDR_W     = 30,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned SIDX_W     = 3,
  parameter int unsigned LOCAL_IDX  = 1,
  parameter int unsigned WBUF_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pl_stall,
  input  logic              pl_flush,
  output logic              busy,
  output logic              err,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_as_,
  input  logic              cpu_rw,
  input  logic [DATA_W-1:0] cpu_wr_data,
  output logic [DATA_W-1:0] cpu_rd_data,
  output logic [ADDR_W-1:0] spm_addr,
  output logic              spm_as_,
  output logic              spm_rw,
  output logic [DATA_W-1:0] spm_wr_data,
  input  logic [DATA_W-1:0] spm_rd_data,
  output logic              bus_req_,
  input  logic              bus_grnt_,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_as_,
  output logic              bus_rw,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_
);

  localparam int unsigned FW    = ADDR_W + DATA_W;
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  bus_state_e        r_state;
  logic              r_is_rd;
  logic [DATA_W-1:0] r_rd_buf;
  logic [CNT_W-1:0]  r_cnt;

  logic [SIDX_W-1:0] w_idx;
  logic              w_local;
  logic              w_go;
  logic              w_rmt_wr;
  logic              w_rmt_rd;
  logic              w_spm_sel;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [FW-1:0]     w_head;
  logic              w_done;
  logic              w_to;
  logic              w_rd_ok;
  logic              w_rd_to;

  assign w_idx     = cpu_addr[ADDR_W-1 -: SIDX_W];
  assign w_local   = (w_idx == SIDX_W'(LOCAL_IDX));
  assign w_go      = (cpu_as_ == STB_ON_) && !pl_flush && !pl_stall;
  assign w_rmt_wr  = w_go && !w_local && (cpu_rw == RW_WRITE);
  assign w_rmt_rd  = w_go && !w_local && (cpu_rw == RW_READ);
  assign w_spm_sel = w_go && w_local && (r_state == ST_IDLE);
  assign w_push    = w_rmt_wr && !w_full;

  // Ready wins over a timeout that expires in the same cycle.
  assign w_done  = (r_state == ST_ACCESS) && (bus_rdy_ == STB_ON_);
  assign w_to    = (TIMEOUT != 0) && !w_done &&
                   ((r_state == ST_REQ) || (r_state == ST_ACCESS)) &&
                   (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_rd_ok = w_done && r_is_rd;
  assign w_rd_to = w_to && r_is_rd;
  assign w_pop   = (w_done || w_to) && !r_is_rd;

  assign spm_addr    = cpu_addr;
  assign spm_rw      = cpu_rw;
  assign spm_wr_data = cpu_wr_data;
  assign spm_as_     = w_spm_sel ? STB_ON_ : STB_OFF_;

  // Full is registered, so a head retiring this cycle never frees a slot for the same-cycle write.
  assign busy = (w_rmt_wr && w_full) ||
                (w_rmt_rd && !w_rd_ok && !w_rd_to) ||
                (w_go && w_local && (r_state != ST_IDLE));

  always_comb begin
    cpu_rd_data = '0;
    if (w_spm_sel && (cpu_rw == RW_READ)) cpu_rd_data = spm_rd_data;
    else if (w_rd_ok)                     cpu_rd_data = bus_rd_data;
    else if (r_state == ST_STALL)         cpu_rd_data = r_rd_buf;
  end

  bus_if_wfifo #(
    .DEPTH (WBUF_DEPTH),
    .WIDTH (FW)
  ) u_wfifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata ({cpu_addr, cpu_wr_data}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_is_rd     <= 1'b0;
      r_rd_buf    <= '0;
      r_cnt       <= '0;
      err         <= 1'b0;
      bus_req_    <= STB_OFF_;
      bus_as_     <= STB_OFF_;
      bus_addr    <= '0;
      bus_wr_data <= '0;
      bus_rw      <= RW_READ;
    end else begin
      err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          // Posted writes drain before any read is launched.
          if (!w_empty) begin
            bus_addr    <= w_head[FW-1 -: ADDR_W];
            bus_wr_data <= w_head[DATA_W-1:0];
            bus_rw      <= RW_WRITE;
            bus_req_    <= STB_ON_;
            r_is_rd     <= 1'b0;
            r_state     <= ST_REQ;
          end else if (w_rmt_rd) begin
            bus_addr    <= cpu_addr;
            bus_wr_data <= '0;
            bus_rw      <= RW_READ;
            bus_req_    <= STB_ON_;
            r_is_rd     <= 1'b1;
            r_state     <= ST_REQ;
          end
        end
        ST_REQ, ST_ACCESS: begin
          bus_as_ <= STB_OFF_;
          if (w_done || w_to) begin
            bus_req_    <= STB_OFF_;
            bus_addr    <= '0;
            bus_wr_data <= '0;
            bus_rw      <= RW_READ;
            err         <= w_to;
            if (r_is_rd) r_rd_buf <= w_done ? bus_rd_data : '0;
            r_state     <= (w_rd_ok && pl_stall) ? ST_STALL : ST_IDLE;
          end else begin
            if (TIMEOUT != 0) r_cnt <= r_cnt + CNT_W'(1);
            if ((r_state == ST_REQ) && (bus_grnt_ == STB_ON_)) begin
              bus_as_ <= STB_ON_;
              r_state <= ST_ACCESS;
            end
          end
        end
        ST_STALL: begin
          if (!pl_stall) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_if_wbuf.sv
// Directed bench for bus_if_wbuf: expected bus transactions are queued at issue and checked when strobed.
module tb_bus_if_wbuf;

  localparam int unsigned AW = 30;
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          rw;
    logic [DW-1:0] data;
  } txn_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          pl_stall, pl_flush;
  logic          busy, err;
  logic [AW-1:0] cpu_addr;
  logic          cpu_as_, cpu_rw;
  logic [DW-1:0] cpu_wr_data, cpu_rd_data;
  logic [AW-1:0] spm_addr;
  logic          spm_as_, spm_rw;
  logic [DW-1:0] spm_wr_data, spm_rd_data;
  logic          bus_req_, bus_grnt_;
  logic [AW-1:0] bus_addr;
  logic          bus_as_, bus_rw;
  logic [DW-1:0] bus_wr_data, bus_rd_data;
  logic          bus_rdy_;

  int   n_tests = 0;
  int   n_fail  = 0;
  txn_t exp_q[$];

  always #5 clk = ~clk;

  bus_if_wbuf dut (
    .clk(clk), .rst(rst), .pl_stall(pl_stall), .pl_flush(pl_flush),
    .busy(busy), .err(err),
    .cpu_addr(cpu_addr), .cpu_as_(cpu_as_), .cpu_rw(cpu_rw),
    .cpu_wr_data(cpu_wr_data), .cpu_rd_data(cpu_rd_data),
    .spm_addr(spm_addr), .spm_as_(spm_as_), .spm_rw(spm_rw),
    .spm_wr_data(spm_wr_data), .spm_rd_data(spm_rd_data),
    .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .bus_addr(bus_addr),
    .bus_as_(bus_as_), .bus_rw(bus_rw), .bus_wr_data(bus_wr_data),
    .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for an address strobe and compares it against the oldest expected transaction.
  task automatic expect_bus(input string tag);
    bit   found;
    txn_t t;
    found = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (bus_as_ === 1'b0) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk({tag, "_strobe"}, 64'(found), 64'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue"}, 64'd0, 64'd1);
    end else begin
      t = exp_q.pop_front();
      if (found) begin
        chk({tag, "_addr"}, 64'(bus_addr), 64'(t.addr));
        chk({tag, "_rw"}, 64'(bus_rw), 64'(t.rw));
        if (t.rw == 1'b0) chk({tag, "_wdata"}, 64'(bus_wr_data), 64'(t.data));
      end
    end
  endtask

  task automatic cpu_req(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_as_     = 1'b0;
    cpu_rw      = rw;
    cpu_addr    = a;
    cpu_wr_data = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t_req, err_t, err_cnt, drop_t, as_cnt, viol;
    logic req_at_err;
    logic [DW-1:0] rdata;
    txn_t tx;

    rst = 1'b0; pl_stall = 1'b0; pl_flush = 1'b0;
    cpu_as_ = 1'b1; cpu_rw = 1'b1; cpu_addr = '0; cpu_wr_data = '0;
    spm_rd_data = '0; bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = '0;
    step();
    chk("rst_req", 64'(bus_req_), 64'd1);
    chk("rst_as", 64'(bus_as_), 64'd1);
    chk("rst_addr", 64'(bus_addr), 64'd0);
    chk("rst_rw", 64'(bus_rw), 64'd1);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_rdata", 64'(cpu_rd_data), 64'd0);
    rst = 1'b1;
    step();

    // Local read served by the SPM in the same cycle.
    cpu_req(1'b1, 30'h0800_0010, '0);
    spm_rd_data = 32'hDEADBEEF;
    #1;
    chk("loc_rdata", 64'(cpu_rd_data), 64'hDEADBEEF);
    chk("loc_busy", 64'(busy), 64'd0);
    chk("loc_spm_as", 64'(spm_as_), 64'd0);
    chk("loc_spm_addr", 64'(spm_addr), 64'h0800_0010);
    chk("loc_req", 64'(bus_req_), 64'd1);
    step();
    cpu_as_ = 1'b1;
    step();

    // Five posted writes into a 4-deep buffer with grant held off.
    for (int i = 0; i < 5; i++) begin
      cpu_req(1'b0, 30'h1000_0000 + AW'(i), 32'hA0 + DW'(i));
      #1;
      chk($sformatf("post_busy%0d", i), 64'(busy), (i == 4) ? 64'd1 : 64'd0);
      if (i < 4) begin
        tx.addr = cpu_addr; tx.rw = 1'b0; tx.data = cpu_wr_data;
        exp_q.push_back(tx);
        step();
      end
    end
    step();
    chk("full_hold_busy", 64'(busy), 64'd1);
    bus_grnt_ = 1'b0;
    step();
    chk("full_access_busy", 64'(busy), 64'd1);
    bus_rdy_ = 1'b0;
    #1;
    chk("full_retire_busy", 64'(busy), 64'd1);
    expect_bus("wr0");
    step();
    chk("full_freed_busy", 64'(busy), 64'd0);
    tx.addr = cpu_addr; tx.rw = 1'b0; tx.data = cpu_wr_data;
    exp_q.push_back(tx);
    step();
    cpu_as_ = 1'b1;
    for (int i = 1; i < 5; i++) begin
      expect_bus($sformatf("wr%0d", i));
      step();
    end
    bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
    step();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_req", 64'(bus_req_), 64'd1);

    // Posted write followed by a read: write must reach the bus first.
    cpu_req(1'b0, 30'h1000_0000, 32'h11112222);
    #1;
    chk("wr_rd_post_busy", 64'(busy), 64'd0);
    tx.addr = 30'h1000_0000; tx.rw = 1'b0; tx.data = 32'h11112222;
    exp_q.push_back(tx);
    step();
    cpu_req(1'b1, 30'h1000_0004, '0);
    tx.addr = 30'h1000_0004; tx.rw = 1'b1; tx.data = '0;
    exp_q.push_back(tx);
    #1;
    chk("rd_busy", 64'(busy), 64'd1);
    bus_grnt_ = 1'b0; bus_rdy_ = 1'b0; bus_rd_data = 32'h12345678;
    expect_bus("order_wr");
    chk("rd_busy_during_wr", 64'(busy), 64'd1);
    step();
    expect_bus("order_rd");
    chk("rd_data", 64'(cpu_rd_data), 64'h12345678);
    chk("rd_done_busy", 64'(busy), 64'd0);
    cpu_as_ = 1'b1;
    step();
    chk("rd_after_zero", 64'(cpu_rd_data), 64'd0);
    bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = '0;
    step();

    // Read completing while the pipeline stalls parks the data.
    cpu_req(1'b1, 30'h1000_0008, '0);
    tx.addr = 30'h1000_0008; tx.rw = 1'b1; tx.data = '0;
    exp_q.push_back(tx);
    bus_grnt_ = 1'b0;
    expect_bus("stall_rd");
    pl_stall = 1'b1; bus_rdy_ = 1'b0; bus_rd_data = 32'hCAFEF00D;
    #1;
    chk("stall_ret", 64'(cpu_rd_data), 64'hCAFEF00D);
    step();
    bus_rdy_ = 1'b1; bus_grnt_ = 1'b1; bus_rd_data = '0;
    #1;
    chk("stall_hold1", 64'(cpu_rd_data), 64'hCAFEF00D);
    chk("stall_busy", 64'(busy), 64'd0);
    step();
    chk("stall_hold2", 64'(cpu_rd_data), 64'hCAFEF00D);
    chk("stall_req", 64'(bus_req_), 64'd1);
    pl_stall = 1'b0; cpu_as_ = 1'b1;
    #1;
    chk("stall_last", 64'(cpu_rd_data), 64'hCAFEF00D);
    step();
    chk("stall_idle", 64'(cpu_rd_data), 64'd0);

    // Flushed remote read is never launched.
    cpu_req(1'b1, 30'h1000_0020, '0);
    pl_flush = 1'b1;
    viol = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (bus_req_ !== 1'b1 || busy !== 1'b0) viol++;
      step();
    end
    chk("flush_no_launch", 64'(viol), 64'd0);
    pl_flush = 1'b0; cpu_as_ = 1'b1;
    step();

    // Grant never arrives: timeout aborts the read with a single err pulse.
    cpu_req(1'b1, 30'h1000_000C, '0);
    t_req = -1; err_t = -1; err_cnt = 0; drop_t = -1; as_cnt = 0;
    req_at_err = 1'b0; rdata = 32'hFFFF_FFFF;
    for (int c = 0; c < 40; c++) begin
      step();
      if (t_req < 0 && bus_req_ === 1'b0) t_req = 0;
      else if (t_req >= 0) t_req++;
      if (bus_as_ === 1'b0) as_cnt++;
      if (err === 1'b1) begin
        err_cnt++;
        if (err_t < 0) begin
          err_t = t_req;
          req_at_err = bus_req_;
        end
      end
      if (cpu_as_ === 1'b0 && busy === 1'b0 && t_req >= 0) begin
        drop_t = t_req;
        rdata = cpu_rd_data;
        cpu_as_ = 1'b1;
      end
    end
    chk("to_err_time", 64'(err_t), 64'd16);
    chk("to_err_once", 64'(err_cnt), 64'd1);
    chk("to_req_released", 64'(req_at_err), 64'd1);
    chk("to_no_strobe", 64'(as_cnt), 64'd0);
    chk("to_busy_drop", 64'(drop_t), 64'd15);
    chk("to_rdata", 64'(rdata), 64'd0);

    // Reset in the middle of an access with writes queued.
    for (int i = 0; i < 3; i++) begin
      cpu_req(1'b0, 30'h1000_0040 + AW'(i), 32'h5000 + DW'(i));
      #1;
      chk($sformatf("rst_post_busy%0d", i), 64'(busy), 64'd0);
      step();
    end
    cpu_as_ = 1'b1;
    bus_grnt_ = 1'b0;
    viol = 1;
    for (int k = 0; k < 20; k++) begin
      if (bus_as_ === 1'b0) begin
        viol = 0;
        break;
      end
      step();
    end
    chk("rst_reach_access", 64'(viol), 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk("arst_req", 64'(bus_req_), 64'd1);
    chk("arst_as", 64'(bus_as_), 64'd1);
    chk("arst_addr", 64'(bus_addr), 64'd0);
    step();
    step();
    rst = 1'b1;
    bus_rdy_ = 1'b0;
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus_req_ !== 1'b1 || bus_as_ !== 1'b1) viol++;
    end
    chk("arst_fifo_empty", 64'(viol), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
